// File: rtl/req_encoder_4x2.sv
// Registered 4-to-2 request encoder: return path of the 2x4 active-low line decoder.
// Latency: req_n low first sampled at edge 1 -> valid high after edge SYNC_STAGES+2.
// Backpressure: code/valid held until ack; further edges on a pending line raise drop.
module req_encoder_4x2 #(
  parameter int SYNC_STAGES = 2,  // legal range 2..4
  parameter int ROUND_ROBIN = 0   // 0 = fixed priority (code 00 highest), 1 = round-robin
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req_n,
  input  logic       ack,
  output logic [1:0] code,
  output logic       valid,
  output logic       multi,
  output logic       drop
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state_q, state_nxt;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] hist_q;
  logic [3:0] fall_line;
  logic [3:0] fall_code;
  logic [3:0] set_mask;
  logic [3:0] clr_mask;
  logic [3:0] pending_q, pending_nxt;
  logic [1:0] rr_ptr_q, rr_ptr_nxt;
  logic [1:0] code_nxt;
  logic       valid_nxt, multi_nxt, drop_nxt;
  logic [1:0] win_code;
  logic [3:0] win_onehot;
  logic [3:0] code_onehot;

  // Synchronizer chain; idle level of the lines is high, so reset to all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1111;
    end else begin
      sync_q[0] <= req_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Previous synced value for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 4'b1111;
    else        hist_q <= sync_q[SYNC_STAGES-1];
  end

  // Line i maps to code 3-i, so the per-code edge vector is the bit-reversed line vector.
  assign fall_line   = hist_q & ~sync_q[SYNC_STAGES-1];
  assign fall_code   = {fall_line[0], fall_line[1], fall_line[2], fall_line[3]};
  assign code_onehot = 4'b0001 << code;
  assign win_onehot  = 4'b0001 << win_code;

  // Winner selection over pending codes: fixed lowest-code or round-robin after rr_ptr.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    win_code = 2'b00;
    found    = 1'b0;
    cand     = 2'b00;
    if (ROUND_ROBIN != 0) begin
      for (int k = 1; k <= 4; k++) begin
        cand = rr_ptr_q + 2'(k);
        if (!found && pending_q[cand]) begin
          win_code = cand;
          found    = 1'b1;
        end
      end
    end else begin
      for (int c = 3; c >= 0; c--) begin
        if (pending_q[c]) win_code = 2'(c);
      end
    end
  end

  // Next-state and output logic for the IDLE/PRESENT handshake.
  always_comb begin
    state_nxt  = state_q;
    code_nxt   = code;
    valid_nxt  = valid;
    multi_nxt  = multi;
    rr_ptr_nxt = rr_ptr_q;
    clr_mask   = 4'b0000;
    case (state_q)
      IDLE: begin
        valid_nxt = 1'b0;
        multi_nxt = 1'b0;
        if (en && (pending_q != 4'b0000)) begin
          state_nxt = PRESENT;
          code_nxt  = win_code;
          valid_nxt = 1'b1;
          multi_nxt = |(pending_q & ~win_onehot);
        end
      end
      PRESENT: begin
        multi_nxt = |(pending_q & ~code_onehot);
        if (ack) begin
          state_nxt  = IDLE;
          valid_nxt  = 1'b0;
          multi_nxt  = 1'b0;
          clr_mask   = code_onehot;
          rr_ptr_nxt = code;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending update: a new edge on the acked line wins over the clear; edges while en=0 are discarded.
  always_comb begin
    set_mask    = en ? fall_code : 4'b0000;
    pending_nxt = (pending_q & ~clr_mask) | set_mask;
    drop_nxt    = |(set_mask & pending_q & ~clr_mask);
  end

  // State register; async reset makes valid drop immediately and loses all pending requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      rr_ptr_q  <= 2'b11;
      code      <= 2'b00;
      valid     <= 1'b0;
      multi     <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pending_q <= pending_nxt;
      rr_ptr_q  <= rr_ptr_nxt;
      code      <= code_nxt;
      valid     <= valid_nxt;
      multi     <= multi_nxt;
      drop      <= drop_nxt;
    end
  end

endmodule
